// File: rtl/inst_feeder.sv
// inst_feeder: fetches instruction words from a synchronous instruction
// memory and issues each one to proc with a one-cycle Run strobe, then waits
// for Done before fetching the next. Halt opcodes stop issue, and a processor
// that never answers trips a sticky error.
module inst_feeder #(
   parameter int         AW      = 5,
   parameter int         TIMEOUT = 4,
   parameter logic [2:0] HALT_OP = 3'b111
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          Start,
   input  logic          Done,
   input  logic [15:0]   mem_data,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   DIN,
   output logic          Run,
   output logic          Busy,
   output logic          Halted,
   output logic          Error,
   output logic [7:0]    instr_count
);

   // Wait counter runs 0..TIMEOUT-1; reaching the last value without Done
   // means the processor has hung.
   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT,
      S_HALTED,
      S_ERROR
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [WCW-1:0] wcnt;
   logic           pc_clr;
   logic           pc_inc;
   logic           din_ld;
   logic           wcnt_clr;
   logic           wcnt_inc;

   // Saturating increment for the issued-instruction counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Next-state and control decode; Start and Done only matter in the
   // states that listen for them.
   always_comb begin
      state_nxt = state;
      pc_clr    = 1'b0;
      pc_inc    = 1'b0;
      din_ld    = 1'b0;
      wcnt_clr  = 1'b0;
      wcnt_inc  = 1'b0;
      case (state)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               pc_clr    = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            if (mem_data[15:13] == HALT_OP) begin
               state_nxt = S_HALTED;
            end else begin
               din_ld    = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pc_inc    = 1'b1;
            wcnt_clr  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (Done) begin
               state_nxt = S_FETCH;
            end else if (wcnt == WCW'(TIMEOUT - 1)) begin
               state_nxt = S_ERROR;
            end else begin
               wcnt_inc = 1'b1;
            end
         end
         S_ERROR:  state_nxt = S_ERROR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register and watchdog counter.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= S_IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         if (wcnt_clr) begin
            wcnt <= '0;
         end else if (wcnt_inc) begin
            wcnt <= wcnt + 1'b1;
         end
      end
   end

   // PC, issued-instruction count and the instruction word held for proc.
   // The PC only moves on Start and at the issue edge, so the memory address
   // stays stable across FETCH and DECODE.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         mem_addr    <= '0;
         instr_count <= '0;
         DIN         <= '0;
      end else begin
         if (pc_clr) begin
            mem_addr    <= '0;
            instr_count <= '0;
         end else if (pc_inc) begin
            mem_addr    <= mem_addr + 1'b1;
            instr_count <= sat_inc8(instr_count);
         end
         if (din_ld) begin
            DIN <= mem_data;
         end
      end
   end

   // Status outputs are registered from the next state so they line up with
   // the state they describe and carry no combinational path from inputs.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         Run    <= 1'b0;
         Busy   <= 1'b0;
         Halted <= 1'b0;
         Error  <= 1'b0;
      end else begin
         Run    <= (state_nxt == S_ISSUE);
         Busy   <= (state_nxt inside {S_FETCH, S_DECODE, S_ISSUE, S_WAIT});
         Halted <= (state_nxt == S_HALTED);
         Error  <= (state_nxt == S_ERROR);
      end
   end

endmodule

// File: tb/tb_inst_feeder.sv
// tb_inst_feeder: directed bench for inst_feeder with a synchronous
// instruction memory and a small behavioural model of proc (mv/mvt finish in
// T1, add/sub in T3, any other opcode never finishes).
module tb_inst_feeder;

   localparam int AW = 5;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic          Start = 1'b0;
   logic          Done;
   logic [15:0]   mem_data;
   logic [AW-1:0] mem_addr;
   logic [15:0]   DIN;
   logic          Run;
   logic          Busy;
   logic          Halted;
   logic          Error;
   logic [7:0]    instr_count;

   logic [15:0]   mem [0:31];

   int n_cmp = 0;
   int n_err = 0;

   inst_feeder #(.AW(AW), .TIMEOUT(4), .HALT_OP(3'b111)) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .Start       (Start),
      .Done        (Done),
      .mem_data    (mem_data),
      .mem_addr    (mem_addr),
      .DIN         (DIN),
      .Run         (Run),
      .Busy        (Busy),
      .Halted      (Halted),
      .Error       (Error),
      .instr_count (instr_count)
   );

   always #5 Clock = ~Clock;

   // Synchronous instruction memory: data valid the cycle after the address.
   always @(posedge Clock) mem_data <= mem[mem_addr];

   // Cycle counter and Run / wrap monitors, sampled away from the active edge.
   int            cyc = 0;
   int            run_cnt = 0;
   int            run_last = 0;
   int            run_prev = 0;
   int            wrap_cnt = 0;
   logic [AW-1:0] prev_addr = '0;
   always @(posedge Clock) cyc <= cyc + 1;
   always @(negedge Clock) begin
      if (Run === 1'b1) begin
         run_cnt  <= run_cnt + 1;
         run_prev <= run_last;
         run_last <= cyc;
      end
      if (prev_addr == 5'd31 && mem_addr == 5'd0 && Busy === 1'b1) wrap_cnt <= wrap_cnt + 1;
      prev_addr <= mem_addr;
   end

   // Behavioural proc: latches DIN when Run is seen in T0.
   logic [1:0]  tstep;
   logic [15:0] ir;
   logic [15:0] R [0:7];
   logic [2:0]  op;
   logic [15:0] operand;
   assign op      = ir[15:13];
   assign operand = ir[12] ? {7'b0, ir[8:0]} : R[ir[2:0]];
   assign Done    = (tstep == 2'd1 && (op == 3'd0 || op == 3'd1)) ||
                    (tstep == 2'd3 && (op == 3'd2 || op == 3'd3));

   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         tstep <= 2'd0;
         ir    <= 16'h0;
         for (int i = 0; i < 8; i++) R[i] <= 16'h0;
      end else if (tstep == 2'd0) begin
         if (Run) begin
            ir    <= DIN;
            tstep <= 2'd1;
         end
      end else if (Done) begin
         case (op)
            3'd0:    R[ir[11:9]] <= operand;
            3'd1:    R[ir[11:9]] <= {ir[7:0], 8'h00};
            3'd2:    R[ir[11:9]] <= R[ir[11:9]] + operand;
            default: R[ir[11:9]] <= R[ir[11:9]] - operand;
         endcase
         tstep <= 2'd0;
      end else if (op == 3'd2 || op == 3'd3) begin
         tstep <= tstep + 2'd1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clock);
   endtask

   // Leaves the caller at the negedge of the first cycle after the Start edge.
   task automatic pulse_start();
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   task automatic wait_stop(input string tag, input int budget, output int at_cyc);
      int n;
      n = 0;
      while (!(Halted === 1'b1 || Error === 1'b1) && n < budget) begin
         tick();
         n++;
      end
      check_eq({tag, " stop reached"}, 32'(Halted === 1'b1 || Error === 1'b1), 32'd1);
      at_cyc = cyc;
   endtask

   int rc0;
   int hc;
   int n;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'hE000;

      // Reset state
      tick();
      tick();
      check_eq("rst Run",    32'(Run),         32'd0);
      check_eq("rst DIN",    32'(DIN),         32'd0);
      check_eq("rst addr",   32'(mem_addr),    32'd0);
      check_eq("rst Busy",   32'(Busy),        32'd0);
      check_eq("rst Halted", 32'(Halted),      32'd0);
      check_eq("rst Error",  32'(Error),       32'd0);
      check_eq("rst count",  32'(instr_count), 32'd0);
      Resetn = 1'b1;
      tick();

      // mv r0,#5 then halt
      mem[0] = 16'h1005;
      mem[1] = 16'hE000;
      rc0 = run_cnt;
      pulse_start();
      check_eq("mv c1 Busy", 32'(Busy), 32'd1);
      check_eq("mv c1 Run",  32'(Run),  32'd0);
      tick();
      check_eq("mv c2 Run",  32'(Run),  32'd0);
      tick();
      check_eq("mv c3 Run",  32'(Run),  32'd1);
      check_eq("mv c3 DIN",  32'(DIN),  32'h1005);
      tick();
      check_eq("mv c4 Run",  32'(Run),  32'd0);
      check_eq("mv c4 Done", 32'(Done), 32'd1);
      wait_stop("mv", 20, hc);
      check_eq("mv Halted", 32'(Halted),      32'd1);
      check_eq("mv addr",   32'(mem_addr),    32'd1);
      check_eq("mv count",  32'(instr_count), 32'd1);
      check_eq("mv runs",   32'(run_cnt - rc0), 32'd1);
      check_eq("mv r0",     32'(R[0]),        32'd5);

      // mv r1,#3 ; add r1,r1 ; halt
      mem[0] = 16'h1203;
      mem[1] = 16'h4201;
      mem[2] = 16'hE000;
      rc0 = run_cnt;
      pulse_start();
      wait_stop("add", 40, hc);
      check_eq("add runs",     32'(run_cnt - rc0),     32'd2);
      check_eq("add mv gap",   32'(run_last - run_prev), 32'd4);
      check_eq("add add gap",  32'(hc - run_last),     32'd6);
      check_eq("add r1",       32'(R[1]),              32'd6);
      check_eq("add count",    32'(instr_count),       32'd2);
      check_eq("add addr",     32'(mem_addr),          32'd2);

      // Immediate halt, twice
      mem[0] = 16'hE000;
      rc0 = run_cnt;
      for (int k = 0; k < 2; k++) begin
         pulse_start();
         check_eq("ih c1 Busy",   32'(Busy),   32'd1);
         check_eq("ih c1 Halted", 32'(Halted), 32'd0);
         tick();
         check_eq("ih c2 Halted", 32'(Halted), 32'd0);
         tick();
         check_eq("ih c3 Halted", 32'(Halted),      32'd1);
         check_eq("ih c3 Busy",   32'(Busy),        32'd0);
         check_eq("ih count",     32'(instr_count), 32'd0);
      end
      check_eq("ih runs", 32'(run_cnt - rc0), 32'd0);

      // Watchdog: opcode 100 never finishes
      mem[0] = 16'h8000;
      rc0 = run_cnt;
      pulse_start();
      tick();
      tick();
      check_eq("wd c3 Run", 32'(Run), 32'd1);
      for (int k = 0; k < 4; k++) tick();
      check_eq("wd c7 Error", 32'(Error), 32'd0);
      check_eq("wd c7 Busy",  32'(Busy),  32'd1);
      tick();
      check_eq("wd c8 Error", 32'(Error), 32'd1);
      check_eq("wd c8 Busy",  32'(Busy),  32'd0);
      pulse_start();
      tick();
      check_eq("wd start Error",  32'(Error),  32'd1);
      check_eq("wd start Busy",   32'(Busy),   32'd0);
      check_eq("wd start Halted", 32'(Halted), 32'd0);
      check_eq("wd runs",         32'(run_cnt - rc0), 32'd1);
      Resetn = 1'b0;
      tick();
      check_eq("wd rst Error", 32'(Error), 32'd0);
      Resetn = 1'b1;
      tick();

      // Wrap-around: halt placed at address 2 once the PC is past it
      for (int i = 0; i < 32; i++) mem[i] = 16'h1401;
      pulse_start();
      n = 0;
      while (mem_addr != 5'd31 && n < 200) begin
         tick();
         n++;
      end
      check_eq("wrap reach 31", 32'(mem_addr), 32'd31);
      mem[2] = 16'hE000;
      wait_stop("wrap", 100, hc);
      check_eq("wrap Halted", 32'(Halted),      32'd1);
      check_eq("wrap addr",   32'(mem_addr),    32'd2);
      check_eq("wrap count",  32'(instr_count), 32'd34);
      check_eq("wrap seen",   32'(wrap_cnt),    32'd1);

      // Reset mid-WAIT of an add
      mem[0] = 16'h1203;
      mem[1] = 16'h4201;
      pulse_start();
      for (int k = 0; k < 7; k++) tick();
      check_eq("rw c8 Busy",  32'(Busy),        32'd1);
      check_eq("rw c8 addr",  32'(mem_addr),    32'd2);
      check_eq("rw c8 count", 32'(instr_count), 32'd2);
      #2 Resetn = 1'b0;
      #1;
      check_eq("rw async Run",   32'(Run),         32'd0);
      check_eq("rw async addr",  32'(mem_addr),    32'd0);
      check_eq("rw async Busy",  32'(Busy),        32'd0);
      check_eq("rw async count", 32'(instr_count), 32'd0);
      tick();
      Resetn = 1'b1;

      // Reset during ISSUE drops Run at once
      pulse_start();
      tick();
      tick();
      check_eq("ri c3 Run", 32'(Run), 32'd1);
      #2 Resetn = 1'b0;
      #1;
      check_eq("ri async Run",  32'(Run),  32'd0);
      check_eq("ri async Busy", 32'(Busy), 32'd0);
      tick();
      Resetn = 1'b1;

      // Re-execution from address 0 after reset
      pulse_start();
      check_eq("re c1 addr", 32'(mem_addr), 32'd0);
      tick();
      tick();
      check_eq("re c3 Run", 32'(Run), 32'd1);
      check_eq("re c3 DIN", 32'(DIN), 32'h1203);
      wait_stop("re", 40, hc);
      check_eq("re r1",    32'(R[1]),        32'd6);
      check_eq("re count", 32'(instr_count), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
